// File: rtl/game_pkg.sv
// Shared game definitions: state encoding for the stage
// progress controller and default character coordinate widths.
package game_pkg;

    typedef enum logic [1:0] {
        REDRAW   = 2'd0,
        PLAY     = 2'd1,
        FINISHED = 2'd2
    } state_t;

    localparam int DEF_X_W = 9;
    localparam int DEF_Y_W = 8;

endpackage

// File: rtl/stage_progress_fsm_zone_hit.sv
// zone_hit: combinational square-zone test around a centre.
// Ports: charX/charY position, zoneX/zoneY centre, hit result.
module zone_hit #(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int ZONE_TOL = 2
) (
    input  logic [X_W-1:0] charX,
    input  logic [Y_W-1:0] charY,
    input  logic [X_W-1:0] zoneX,
    input  logic [Y_W-1:0] zoneY,
    output logic           hit
);

    localparam logic [X_W:0] TX = (X_W+1)'(ZONE_TOL);
    localparam logic [Y_W:0] TY = (Y_W+1)'(ZONE_TOL);

    logic [X_W:0] dx;
    logic [Y_W:0] dy;

    // Guard bit holds the sign of the difference, so the
    // absolute distance never wraps at either coordinate end.
    always_comb begin
        dx = {1'b0, charX} - {1'b0, zoneX};
        if (dx[X_W]) dx = -dx;
        dy = {1'b0, charY} - {1'b0, zoneY};
        if (dy[Y_W]) dy = -dy;
        hit = (dx <= TX) && (dy <= TY);
    end

endmodule

// File: rtl/stage_progress_fsm.sv
// Stage progress controller: walks puzzle stages on key
// activation inside forward/backward zones, requests map redraws,
// and latches completion when the goal zone is reached.
// Ports: clock, resetn (sync, active-low), activate, spriteDead,
// doneRedraw, charX/charY, per-stage zone centres, goal centre;
// outputs stage, redrawReq, updating, finished.
module stage_progress_fsm
    import game_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int ZONE_TOL   = 2,
    parameter int SW         = $clog2(NUM_STAGES)
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  activate,
    input  logic                  spriteDead,
    input  logic                  doneRedraw,
    input  logic [X_W-1:0]        charX,
    input  logic [Y_W-1:0]        charY,
    input  logic [NUM_STAGES*X_W-1:0] fwdZoneX,
    input  logic [NUM_STAGES*Y_W-1:0] fwdZoneY,
    input  logic [NUM_STAGES*X_W-1:0] backZoneX,
    input  logic [NUM_STAGES*Y_W-1:0] backZoneY,
    input  logic [X_W-1:0]        goalX,
    input  logic [Y_W-1:0]        goalY,
    output logic [SW-1:0]         stage,
    output logic                  redrawReq,
    output logic                  updating,
    output logic                  finished
);

    localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);

    state_t state;
    logic   act_q;
    logic   ev;
    logic   fwd_hit;
    logic   back_hit;
    logic   goal_hit;

    logic [X_W-1:0] fzx;
    logic [Y_W-1:0] fzy;
    logic [X_W-1:0] bzx;
    logic [Y_W-1:0] bzy;

    assign fzx = fwdZoneX[int'(stage)*X_W +: X_W];
    assign fzy = fwdZoneY[int'(stage)*Y_W +: Y_W];
    assign bzx = backZoneX[int'(stage)*X_W +: X_W];
    assign bzy = backZoneY[int'(stage)*Y_W +: Y_W];

    assign ev = activate & ~act_q;

    zone_hit #(.X_W(X_W), .Y_W(Y_W), .ZONE_TOL(ZONE_TOL)) u_fwd (
        .charX(charX), .charY(charY),
        .zoneX(fzx), .zoneY(fzy), .hit(fwd_hit)
    );

    zone_hit #(.X_W(X_W), .Y_W(Y_W), .ZONE_TOL(ZONE_TOL)) u_back (
        .charX(charX), .charY(charY),
        .zoneX(bzx), .zoneY(bzy), .hit(back_hit)
    );

    zone_hit #(.X_W(X_W), .Y_W(Y_W), .ZONE_TOL(ZONE_TOL)) u_goal (
        .charX(charX), .charY(charY),
        .zoneX(goalX), .zoneY(goalY), .hit(goal_hit)
    );

    // redrawReq doubles as the "first REDRAW cycle" marker, which
    // is why doneRedraw is ignored while it is high.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= REDRAW;
            stage     <= '0;
            act_q     <= 1'b0;
            redrawReq <= 1'b1;
            updating  <= 1'b1;
            finished  <= 1'b0;
        end else begin
            act_q     <= activate;
            redrawReq <= 1'b0;
            unique case (state)
                REDRAW: begin
                    if (spriteDead) begin
                        stage     <= '0;
                        redrawReq <= 1'b1;
                    end else if (doneRedraw && !redrawReq) begin
                        state    <= PLAY;
                        updating <= 1'b0;
                    end
                end
                PLAY: begin
                    if (spriteDead) begin
                        stage     <= '0;
                        state     <= REDRAW;
                        redrawReq <= 1'b1;
                        updating  <= 1'b1;
                    end else if (ev && fwd_hit) begin
                        // A forward hit shadows the backward zone even
                        // when it cannot advance from the last stage.
                        if (stage != LAST) begin
                            stage     <= stage + 1'b1;
                            state     <= REDRAW;
                            redrawReq <= 1'b1;
                            updating  <= 1'b1;
                        end
                    end else if (ev && back_hit && stage != '0) begin
                        stage     <= stage - 1'b1;
                        state     <= REDRAW;
                        redrawReq <= 1'b1;
                        updating  <= 1'b1;
                    end else if (stage == LAST && goal_hit) begin
                        state    <= FINISHED;
                        finished <= 1'b1;
                    end
                end
                FINISHED: begin
                    finished <= 1'b1;
                end
                default: begin
                    state     <= REDRAW;
                    stage     <= '0;
                    redrawReq <= 1'b1;
                    updating  <= 1'b1;
                    finished  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_progress_fsm.sv
// Scoreboard bench for stage_progress_fsm: directed scenarios
// followed by randomized play against a cycle-level game model.
module tb_stage_progress_fsm;

    localparam int NS  = 4;
    localparam int XW  = 9;
    localparam int YW  = 8;
    localparam int TOL = 2;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic activate = 1'b0;
    logic spriteDead = 1'b0;
    logic doneRedraw = 1'b0;
    logic [XW-1:0] charX = '0;
    logic [YW-1:0] charY = '0;
    logic [NS*XW-1:0] fwdZoneX;
    logic [NS*YW-1:0] fwdZoneY;
    logic [NS*XW-1:0] backZoneX;
    logic [NS*YW-1:0] backZoneY;
    logic [XW-1:0] goalX;
    logic [YW-1:0] goalY;
    logic [1:0] stage;
    logic redrawReq;
    logic updating;
    logic finished;

    int fx[NS] = '{10, 150, 250, 350};
    int fy[NS] = '{10, 80, 120, 160};
    int bx[NS] = '{40, 150, 0, 300};
    int by[NS] = '{40, 81, 0, 200};
    int gx = 510;
    int gy = 254;

    int cx = 0;
    int cy = 0;

    typedef struct {
        bit rr;
        bit upd;
        bit fin;
        int stg;
    } exp_t;

    exp_t sbq[$];
    int tests = 0;
    int fails = 0;

    // model: game progress in plain terms
    int m_stage;
    bit m_play;
    bit m_fin;
    bit m_first;
    bit m_prev;
    bit mvalid = 1'b0;

    stage_progress_fsm #(
        .NUM_STAGES(NS), .X_W(XW), .Y_W(YW), .ZONE_TOL(TOL)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .activate(activate),
        .spriteDead(spriteDead),
        .doneRedraw(doneRedraw),
        .charX(charX),
        .charY(charY),
        .fwdZoneX(fwdZoneX),
        .fwdZoneY(fwdZoneY),
        .backZoneX(backZoneX),
        .backZoneY(backZoneY),
        .goalX(goalX),
        .goalY(goalY),
        .stage(stage),
        .redrawReq(redrawReq),
        .updating(updating),
        .finished(finished)
    );

    always #5 clock = ~clock;

    function automatic bit near(int px, int py, int zx, int zy);
        return (px - zx <= TOL) && (zx - px <= TOL) &&
               (py - zy <= TOL) && (zy - py <= TOL);
    endfunction

    function automatic void model(bit rn, bit a, bit d, bit dn);
        bit ev;
        bit was_first;
        bit fh;
        bit bh;
        bit gh;
        if (!rn) begin
            m_stage = 0;
            m_play  = 0;
            m_fin   = 0;
            m_first = 1;
            m_prev  = 0;
            mvalid  = 1;
            return;
        end
        ev = a && !m_prev;
        m_prev = a;
        was_first = m_first;
        m_first = 0;
        if (m_fin) begin
        end else if (d) begin
            m_stage = 0;
            m_play  = 0;
            m_first = 1;
        end else if (!m_play) begin
            if (dn && !was_first) m_play = 1;
        end else begin
            fh = near(cx, cy, fx[m_stage], fy[m_stage]);
            bh = near(cx, cy, bx[m_stage], by[m_stage]);
            gh = near(cx, cy, gx, gy);
            if (ev && fh) begin
                if (m_stage < NS - 1) begin
                    m_stage = m_stage + 1;
                    m_play  = 0;
                    m_first = 1;
                end
            end else if (ev && bh && m_stage > 0) begin
                m_stage = m_stage - 1;
                m_play  = 0;
                m_first = 1;
            end else if (m_stage == NS - 1 && gh) begin
                m_play = 0;
                m_fin  = 1;
            end
        end
    endfunction

    task automatic cyc(input bit rn, input bit a, input bit d, input bit dn);
        exp_t e;
        @(posedge clock);
        #1;
        if (mvalid) begin
            e.rr  = m_first;
            e.upd = !m_play && !m_fin;
            e.fin = m_fin;
            e.stg = m_stage;
            sbq.push_back(e);
        end
        resetn     = rn;
        activate   = a;
        spriteDead = d;
        doneRedraw = dn;
        charX      = XW'(cx);
        charY      = YW'(cy);
        model(rn, a, d, dn);
    endtask

    task automatic chk(input string nm, input int es, input bit eu, input bit ef);
        @(negedge clock);
        tests++;
        if (int'(stage) != es || updating !== eu || finished !== ef) begin
            fails++;
            $display("FAIL %s: got stage=%0d upd=%0b fin=%0b, want stage=%0d upd=%0b fin=%0b",
                     nm, stage, updating, finished, es, eu, ef);
        end
    endtask

    task automatic advance(input int px, input int py);
        cx = px;
        cy = py;
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
    endtask

    // monitor: every cycle the DUT presents its registered outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                tests++;
                if (redrawReq !== e.rr || updating !== e.upd ||
                    finished !== e.fin || int'(stage) != e.stg) begin
                    fails++;
                    $display("FAIL cycle_rec @%0t: got rr=%0b upd=%0b fin=%0b stage=%0d, want rr=%0b upd=%0b fin=%0b stage=%0d",
                             $time, redrawReq, updating, finished, stage,
                             e.rr, e.upd, e.fin, e.stg);
                end
            end
        end
    end

    initial begin
        int r;
        int sel;
        int zx;
        int zy;
        bit a;
        for (int k = 0; k < NS; k++) begin
            fwdZoneX[k*XW +: XW]  = XW'(fx[k]);
            fwdZoneY[k*YW +: YW]  = YW'(fy[k]);
            backZoneX[k*XW +: XW] = XW'(bx[k]);
            backZoneY[k*YW +: YW] = YW'(by[k]);
        end
        goalX = XW'(gx);
        goalY = YW'(gy);

        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        chk("reset_to_play", 0, 0, 0);

        cx = 13; cy = 10;
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("offset_3_0", 0, 0, 0);

        cx = 12; cy = 8;
        repeat (10) cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("held_key", 1, 1, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        chk("play_s1", 1, 0, 0);

        cx = 150; cy = 80;
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("fwd_priority", 2, 1, 0);

        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        chk("dead_redraw", 0, 1, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        chk("play_s0", 0, 0, 0);

        cx = 40; cy = 40;
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("back_s0", 0, 0, 0);

        cyc(1, 0, 1, 0);
        cx = 10; cy = 10;
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 1);
        repeat (3) cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("held_thru_redraw", 0, 0, 0);

        advance(10, 10);
        advance(150, 80);
        advance(250, 120);
        chk("stage3", 3, 0, 0);

        cx = 350; cy = 160;
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("fwd_last", 3, 0, 0);

        cx = 0; cy = 0;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("no_wrap", 3, 0, 0);

        cx = 511; cy = 255;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("goal", 3, 0, 1);

        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("absorb", 3, 0, 1);

        for (int rnd = 0; rnd < 4; rnd++) begin
            cyc(0, 0, 0, 1'($urandom % 2));
            a = 0;
            for (int i = 0; i < 400; i++) begin
                r = int'($urandom % 4);
                if (r == 0) begin
                    cx = int'($urandom % 512);
                    cy = int'($urandom % 256);
                end else begin
                    sel = int'($urandom % 3);
                    zx = (sel == 0) ? fx[m_stage] : (sel == 1) ? bx[m_stage] : gx;
                    zy = (sel == 0) ? fy[m_stage] : (sel == 1) ? by[m_stage] : gy;
                    cx = zx + int'($urandom_range(0, 6)) - 3;
                    cy = zy + int'($urandom_range(0, 6)) - 3;
                    if (cx < 0) cx = 0;
                    if (cx > 511) cx = 511;
                    if (cy < 0) cy = 0;
                    if (cy > 255) cy = 255;
                end
                if ($urandom % 3 == 0) a = ~a;
                cyc(1, a, ($urandom % 60) == 0, ($urandom % 4) == 0);
            end
        end

        cyc(1, 0, 0, 0);
        @(negedge clock);
        @(negedge clock);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stage_progress_fsm.md
STAGE_PROGRESS_FSM -- requirements
Module: stage_progress_fsm

Interface
REQ-001 Parameter NUM_STAGES, default 4, number of puzzle stages (2..16); stage 0 is the initial layout.
REQ-002 Parameter X_W, default 9, character X coordinate width.
REQ-003 Parameter Y_W, default 8, character Y coordinate width.
REQ-004 Parameter ZONE_TOL, default 2, half-width in pixels of every square activation zone.
REQ-005 Parameter SW, default $clog2(NUM_STAGES), stage index width.
REQ-006 clock  in  1  system clock; all logic is on its rising edge.
REQ-007 resetn  in  1  reset, synchronous, active-low.
REQ-008 activate  in  1  level key input; only its rising edge is used.
REQ-009 spriteDead  in  1  level; the character has died.
REQ-010 doneRedraw  in  1  single-cycle pulse from the map drawer: redraw complete.
REQ-011 charX  in  X_W  character X; charY  in  Y_W  character Y.
REQ-012 fwdZoneX/fwdZoneY  in  NUM_STAGES*X_W / NUM_STAGES*Y_W  forward zone centre per stage, stage k in slice k.
REQ-013 backZoneX/backZoneY  in  NUM_STAGES*X_W / NUM_STAGES*Y_W  backward zone centre per stage.
REQ-014 goalX/goalY  in  X_W / Y_W  goal zone centre, used only in the last stage.
REQ-015 stage  out  SW  currently displayed stage index.
REQ-016 redrawReq  out  1  single-cycle pulse requesting a map redraw of stage.
REQ-017 updating  out  1  high while a redraw is outstanding.
REQ-018 finished  out  1  high in FINISHED.

Function
REQ-019 States: REDRAW, PLAY, FINISHED; stage is a separate SW-bit register.
REQ-020 Zone hit when |charX-zoneX| <= ZONE_TOL and |charY-zoneY| <= ZONE_TOL, computed unsigned with one guard bit; no wrap-around at coordinate 0 or the maximum.
REQ-021 Activation event = activate high this cycle and low the previous cycle; a held key yields one event only.
REQ-022 PLAY, event, forward hit of current stage, stage < NUM_STAGES-1: stage <= stage+1, go to REDRAW.
REQ-023 PLAY, event, backward hit, stage > 0: stage <= stage-1, go to REDRAW.
REQ-024 Forward and backward hits in the same cycle: forward wins.
REQ-025 Forward hit in the last stage or backward hit in stage 0: ignored, remain in PLAY.
REQ-026 PLAY, stage = NUM_STAGES-1, goal hit (no activate needed): go to FINISHED next cycle.
REQ-027 spriteDead in PLAY or REDRAW: stage <= 0, go to REDRAW; it takes priority over every other transition.
REQ-028 Every entry into REDRAW asserts redrawReq for exactly the first cycle in that state.
REQ-029 REDRAW leaves to PLAY on doneRedraw; doneRedraw in the redrawReq cycle or while in PLAY/FINISHED is ignored.
REQ-030 Activation events and goal hits are ignored in REDRAW; the edge detector keeps tracking, so a key held through a redraw yields no event.
REQ-031 updating = 1 in every REDRAW cycle, else 0.
REQ-032 FINISHED is absorbing until reset; spriteDead is ignored there.
REQ-033 stage changes only on the transition into REDRAW, so it is stable throughout each redraw.

Reset
REQ-034 With resetn low at a rising edge: state = REDRAW, stage = 0, edge register = 0, finished = 0, updating = 1.
REQ-035 The first cycle after reset releases counts as REDRAW entry: redrawReq = 1 in that cycle.
REQ-036 Reset mid-redraw abandons the redraw; a doneRedraw arriving in the reset cycle is ignored.

Structure
REQ-037 A shared package game_pkg holds the state encoding (REDRAW=0, PLAY=1, FINISHED=2, 2 bits) and default coordinate widths.
REQ-038 One sub-module zone_hit (parameters X_W, Y_W, ZONE_TOL; purely combinational) is instantiated for the forward, backward and goal comparisons.

Verification
REQ-039 Reset -> redrawReq one pulse, stage=0; doneRedraw 3 cycles later -> PLAY, updating=0.
REQ-040 stage 0, char at fwdZone0+(2,-2), activate held 10 cycles -> one advance: stage=1, one redrawReq; at offset (3,0) -> no change.
REQ-041 stage 1, char at a point that is both forward and backward zone, activate edge -> stage=2 (forward priority); backward hit in stage 0 -> ignored.
REQ-042 stage 3 (NUM_STAGES=4), char enters goal zone with no activate -> finished=1 next cycle; later spriteDead -> still FINISHED.
REQ-043 stage 2 mid-redraw, spriteDead pulse -> stage=0, fresh redrawReq; doneRedraw coincident with that redrawReq is ignored; the next doneRedraw -> PLAY.
REQ-044 Activate edge during REDRAW, key held through doneRedraw -> no transition after returning to PLAY.
